// File: rtl/alu_cmd_feeder.sv
// Command FIFO in front of the 4-bit ALU: buffers {select, A, B} commands and
// holds each on the ALU inputs for HOLD clocks, flagging the cycle its result is stable.
module alu_cmd_feeder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [4:0]               in_sel,
    output logic [3:0]               A,
    output logic [3:0]               B,
    output logic [4:0]               select,
    output logic                     issue_valid,
    output logic                     res_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CW-1:0]            issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t          state, state_nx;
    logic [12:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [HW-1:0]   hold_cnt;
    logic            push, pop, done;

    // in_ready looks only at registered occupancy, so a full FIFO never accepts
    // even when a pop happens in the same cycle.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready && !res;
    assign done     = (state == DRIVE) && (hold_cnt == '0);
    assign pop      = ((state == IDLE) || done) && (count != '0);

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count != '0) state_nx = DRIVE;
            DRIVE:   if (done)        state_nx = (count != '0) ? DRIVE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue_valid = (state == DRIVE);
        res_valid   = done;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_sel, in_a, in_b};
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= '0;
            A        <= '0;
            B        <= '0;
            select   <= '0;
            issued   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Back-to-back issue: a pop on the finishing edge reloads without a bubble.
            if (pop) begin
                {select, A, B} <= mem[rd_ptr];
                rd_ptr         <= rd_ptr + 1'b1;
                hold_cnt       <= HOLD_LAST;
            end else if (done) begin
                {select, A, B} <= '0;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (done) issued <= issued + 1'b1;
        end
    end

endmodule
